// File: rtl/chad_intc.sv
// ---------------------------------------------------------------------------
// chad_intc -- interrupt controller for the Chad core's irq/ivec/iack port.
//
// Rising edges on the NSRC peripheral lines are synchronized and latched into
// PENDING. The lowest-index request that is both pending and enabled is
// offered to the core as a registered irq with a 4-bit vector (source k uses
// vector k+1). Once the core acknowledges, the controller stays in service
// and offers nothing new until software writes EOI.
//
// Handshake: irq/ivec are stable while in REQ. An acknowledge is taken on a
// clock edge where iack=1 and hold=0; iack while hold=1 is ignored. A taken
// acknowledge drops irq and ivec on that same edge.
//
// Ports
//   clk, reset      core clock, synchronous active-high reset
//   hold            core hold; masks iack
//   src[NSRC]       asynchronous rising-edge interrupt lines
//   irq, ivec[4]    request and vector to the core (ivec=0 while irq=0)
//   iack            acknowledge from the core
//   io_addr[2]      register select: 0 ENABLE, 1 PENDING, 2 force/status,
//                   3 EOI/src levels
//   io_wr, io_rd    I/O strobes
//   din[WIDTH]      write data
//   io_dout[WIDTH]  registered read data, valid one edge after io_rd
// ---------------------------------------------------------------------------
module chad_intc #(
  parameter int WIDTH = 18,
  parameter int NSRC  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [NSRC-1:0]  src,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack,
  input  logic [1:0]       io_addr,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] io_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_INSVC = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] sync1, sync2, sync3;
  logic [1:0]      warm_cnt;
  logic            warm_done;
  logic [NSRC-1:0] enable, enable_next;
  logic [NSRC-1:0] pending, pend_sw, pend_next;
  logic [NSRC-1:0] rise, req, vec_mask;
  logic [3:0]      vec_q, vec_next, win_vec, ivec_d;
  logic            any_req, ack, withdraw, irq_d;
  logic            wr0, wr1, wr2, wr3;
  logic [WIDTH-1:0] rd_data;

  // Only the low NSRC bits of the write data are meaningful.
  logic unused_din;
  assign unused_din = &{1'b0, din[WIDTH-1:NSRC]};

  assign wr0 = io_wr && (io_addr == 2'd0);
  assign wr1 = io_wr && (io_addr == 2'd1);
  assign wr2 = io_wr && (io_addr == 2'd2);
  assign wr3 = io_wr && (io_addr == 2'd3);

  // Edge detection is held off until the synchronizer carries real input
  // levels and the edge flop has copied them once, so a line that was high
  // through reset is treated as a level, not as an edge.
  assign warm_done = (warm_cnt == 2'd3);
  assign rise      = sync2 & ~sync3 & {NSRC{warm_done}};

  // Lowest index wins: scan downward so the last hit is the smallest index.
  assign req = pending & enable;
  always_comb begin
    any_req = 1'b0;
    win_vec = 4'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        any_req = 1'b1;
        win_vec = 4'(k + 1);
      end
    end
  end

  // One-hot mask of the source behind the latched vector.
  always_comb begin
    vec_mask = '0;
    for (int k = 0; k < NSRC; k++) vec_mask[k] = (vec_q == 4'(k + 1));
  end

  assign ack         = (state == ST_REQ) && iack && !hold;
  assign enable_next = wr0 ? din[NSRC-1:0] : enable;

  // Software clear, then software set, then the acknowledge clear; a fresh
  // edge is ORed in last so it survives any clear on the same edge.
  always_comb begin
    pend_sw = pending;
    if (wr1) pend_sw = pend_sw & ~din[NSRC-1:0];
    if (wr2) pend_sw = pend_sw | din[NSRC-1:0];
    pend_next = (pend_sw & ~(ack ? vec_mask : '0)) | rise;
  end

  // Request withdrawn when the active source loses its pending or enable bit.
  assign withdraw = ((pend_next & enable_next & vec_mask) == '0);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req) state_next = ST_REQ;
      ST_REQ: begin
        if (ack)           state_next = ST_INSVC;
        else if (withdraw) state_next = ST_IDLE;
      end
      ST_INSVC: if (wr3) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic: irq/ivec are computed for the next state and registered.
  always_comb begin
    irq_d    = (state_next == ST_REQ);
    vec_next = ((state == ST_IDLE) && (state_next == ST_REQ)) ? win_vec : vec_q;
    ivec_d   = irq_d ? vec_next : 4'd0;
  end

  always_comb begin
    rd_data = '0;
    case (io_addr)
      2'd0: rd_data[NSRC-1:0] = enable;
      2'd1: rd_data[NSRC-1:0] = pending;
      2'd2: rd_data[5:0]      = {state, vec_q};
      2'd3: rd_data[NSRC-1:0] = sync2;
      default: rd_data = '0;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      warm_cnt <= 2'd0;
      enable   <= '0;
      pending  <= '0;
      vec_q    <= 4'd0;
      irq      <= 1'b0;
      ivec     <= 4'd0;
      io_dout  <= '0;
    end else begin
      state    <= state_next;
      sync1    <= src;
      sync2    <= sync1;
      sync3    <= sync2;
      if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
      enable   <= enable_next;
      pending  <= pend_next;
      vec_q    <= vec_next;
      irq      <= irq_d;
      ivec     <= ivec_d;
      if (io_rd) io_dout <= rd_data;
    end
  end

endmodule
